// File: rtl/aes_cap_pkg.sv
// ============================================================================
// Module   : aes_cap_pkg
// Purpose  : Shared types and default sizing for the AES output capture stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_cap_pkg;

   localparam int CAP_LATENCY_DEF    = 11;
   localparam int CAP_FIFO_DEPTH_DEF = 4;
   localparam int CAP_ID_W           = 4;

   // Tag travelling alongside a block through the core pipeline
   typedef struct packed {
      logic                valid;
      logic [CAP_ID_W-1:0] id;
      logic                ed;
   } cap_tag_t;

   // One buffered result
   typedef struct packed {
      logic [127:0]        data;
      logic [CAP_ID_W-1:0] id;
      logic                ed;
   } cap_entry_t;

endpackage

`default_nettype wire

// File: rtl/aes_out_capture_if.sv
// ============================================================================
// Module   : aes_out_capture_if
// Purpose  : Issue / core-result / drain bundle of the AES output capture stage.
//            master = block feeding issues and consuming results,
//            slave  = the capture stage itself.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_out_capture_if
   import aes_cap_pkg::*;
#(
   parameter int ID_W       = CAP_ID_W,
   parameter int FIFO_DEPTH = CAP_FIFO_DEPTH_DEF
);
   localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [ID_W-1:0]   in_id;
   logic              in_ed;
   logic [127:0]      aes_dout;
   logic              out_valid;
   logic              out_ready;
   logic [127:0]      out_data;
   logic [ID_W-1:0]   out_id;
   logic              out_ed;
   logic [CRED_W-1:0] credits;
   logic              err;

   modport master (
      output in_valid, in_id, in_ed, aes_dout, out_ready,
      input  in_ready, out_valid, out_data, out_id, out_ed, credits, err
   );

   modport slave (
      input  in_valid, in_id, in_ed, aes_dout, out_ready,
      output in_ready, out_valid, out_data, out_id, out_ed, credits, err
   );

endinterface

`default_nettype wire

// File: rtl/aes_cap_fifo.sv
// ============================================================================
// Module   : aes_cap_fifo
// Purpose  : Synchronous result FIFO. Pointers carry one extra wrap bit so
//            full and empty are distinguishable. A write on a full FIFO is
//            accepted only if a read happens in the same cycle (the read frees
//            the head slot, which the write then fills as the new tail).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_cap_fifo
   import aes_cap_pkg::*;
#(
   parameter int DEPTH = CAP_FIFO_DEPTH_DEF
)(
   input  wire logic                     clk,
   input  wire logic                     rst_n,
   input  wire logic                     i_wr_en,
   input  wire cap_entry_t               i_wr_data,
   input  wire logic                     i_rd_en,
   output cap_entry_t                    o_rd_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(DEPTH):0]        o_count
);
   localparam int AW = $clog2(DEPTH);

   cap_entry_t   r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_do_wr;
   logic         w_do_rd;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

   assign w_do_rd = i_rd_en & ~o_empty;
   assign w_do_wr = i_wr_en & (~o_full | w_do_rd);

   // Storage and pointer update; reset clears contents so the head reads zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
            r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_do_rd) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/aes_out_capture.sv
// ============================================================================
// Module   : aes_out_capture
// Purpose  : Output capture for a non-stallable pipelined AES core. Each issued
//            block gets a tag that walks a LATENCY-deep shift register; when it
//            reaches the end the core result is captured into a small FIFO.
//            Issue is credit-limited so in-flight + buffered never exceeds the
//            FIFO depth.
// Options  : AES_CAP_STATS_EN - adds blk_count / stall_count statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_out_capture
   import aes_cap_pkg::*;
#(
   parameter int LATENCY    = CAP_LATENCY_DEF,
   parameter int FIFO_DEPTH = CAP_FIFO_DEPTH_DEF,
   parameter int ID_W       = CAP_ID_W
)(
   input  wire logic          clk,
   input  wire logic          rst_n,
   aes_out_capture_if.slave   bus
`ifdef AES_CAP_STATS_EN
   ,
   output logic [31:0]        blk_count,
   output logic [31:0]        stall_count
`endif
);
   localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0]    c_DEPTH = (CW+1)'(FIFO_DEPTH);

   cap_tag_t      r_tag [LATENCY];
   logic [CW-1:0] r_in_flight;
   logic          r_err;

   logic          w_issue;
   cap_tag_t      w_cap_tag;
   logic          w_cap_vld;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_occ;
   logic [CW:0]   w_used;
   cap_entry_t    w_wr_entry;
   cap_entry_t    w_head;

   assign w_issue    = bus.in_valid & bus.in_ready;
   assign w_cap_tag  = r_tag[LATENCY-1];
   assign w_cap_vld  = w_cap_tag.valid;
   assign w_pop      = bus.out_ready & ~w_empty;
   assign w_wr_entry = {bus.aes_dout, w_cap_tag.id, w_cap_tag.ed};

   // Credits come from registered counts only, so out_ready never reaches in_ready
   assign w_used       = {1'b0, r_in_flight} + {1'b0, w_occ};
   assign bus.in_ready = (w_used < c_DEPTH);
   assign bus.credits  = bus.in_ready ? CW'(c_DEPTH - w_used) : '0;

   assign bus.out_valid = ~w_empty;
   assign bus.out_data  = w_head.data;
   assign bus.out_id    = ID_W'(w_head.id);
   assign bus.out_ed    = w_head.ed;
   assign bus.err       = r_err;

   // Tag shift register: stage 0 loads on issue, last stage triggers capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LATENCY; k++) begin
            r_tag[k] <= '0;
         end
      end else begin
         r_tag[0] <= w_issue ? {1'b1, CAP_ID_W'(bus.in_id), bus.in_ed} : '0;
         for (int k = 1; k < LATENCY; k++) begin
            r_tag[k] <= r_tag[k-1];
         end
      end
   end

   // In-flight count; a capture with nothing in flight cannot underflow it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_flight <= '0;
      end else begin
         case ({w_issue, w_cap_vld})
            2'b10:   r_in_flight <= r_in_flight + CW'(1);
            2'b01:   if (r_in_flight != '0) r_in_flight <= r_in_flight - CW'(1);
            default: r_in_flight <= r_in_flight;
         endcase
      end
   end

   // Sticky error: a capture found the FIFO full with no pop to make room
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_cap_vld & w_full & ~w_pop) begin
         r_err <= 1'b1;
      end
   end

   aes_cap_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_cap_vld),
      .i_wr_data (w_wr_entry),
      .i_rd_en   (bus.out_ready),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_occ)
   );

`ifdef AES_CAP_STATS_EN
   logic [31:0] r_blk_count;
   logic [31:0] r_stall_count;

   assign blk_count   = r_blk_count;
   assign stall_count = r_stall_count;

   // Wrapping pop count and saturating count of refused issue attempts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blk_count   <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_pop) begin
            r_blk_count <= r_blk_count + 32'd1;
         end
         if (bus.in_valid & ~bus.in_ready & (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire
